// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW  = 2'd0,
        W_HIGH = 2'd1,
        S_HIGH = 2'd2,
        W_LOW  = 2'd3
    } db_state_t;

    // 10 ms worth of stable samples at a 100 MHz board clock.
    localparam int DB_CNT_100MHZ_10MS = 1000000;

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop synchronizer, level-qualification FSM and
// stability counter, with registered level and edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_MAX = DB_CNT_100MHZ_10MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_db,
    output logic o_rise,
    output logic o_fall
);

    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;
    logic             r_rise;
    logic             r_fall;

    db_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_db_nxt;
    logic             w_rise_nxt;
    logic             w_fall_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_LOW;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= w_db_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // The counter only advances while the synchronized level disagrees with
    // the accepted level; any agreement sends the channel back to its stable state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        unique case (r_state)
            S_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = W_HIGH;
                    w_cnt_nxt   = '0;
                end
            end
            W_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (!r_sync2) begin
                    w_state_nxt = W_LOW;
                    w_cnt_nxt   = '0;
                end
            end
            W_LOW: begin
                if (r_sync2) begin
                    w_state_nxt = S_HIGH;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_LOW;
                    w_cnt_nxt   = '0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_LOW;
                w_cnt_nxt   = '0;
            end
        endcase
        w_db_nxt = (w_state_nxt == S_HIGH) || (w_state_nxt == W_LOW);
    end

    assign o_db   = r_db;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button/switch conditioner: one independent debounce_channel
// per input bit.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int CNT_MAX = DB_CNT_100MHZ_10MS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] btn_in,
    output logic [WIDTH-1:0] btn_db,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    if (CNT_MAX < 1) begin : g_bad_cnt_max
        $error("button_debouncer: CNT_MAX must be >= 1");
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
        debounce_channel #(
            .CNT_MAX (CNT_MAX)
        ) u_chan (
            .clk    (clk),
            .rst_n  (rst_n),
            .i_btn  (btn_in[gi]),
            .o_db   (btn_db[gi]),
            .o_rise (rise_pulse[gi]),
            .o_fall (fall_pulse[gi])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench: a run-length reference model predicts every cycle's
// outputs into a queue, and an independent monitor pops and compares.
module tb_button_debouncer;

    localparam int WIDTH   = 3;
    localparam int CNT_MAX = 4;

    typedef struct packed {
        logic [WIDTH-1:0] db;
        logic [WIDTH-1:0] rise;
        logic [WIDTH-1:0] fall;
    } expect_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic [WIDTH-1:0] btnIn = '0;
    logic [WIDTH-1:0] btnDb;
    logic [WIDTH-1:0] risePulse;
    logic [WIDTH-1:0] fallPulse;

    expect_t          expQ[$];
    bit               modelOn = 1'b0;
    logic [WIDTH-1:0] histNew;
    logic [WIDTH-1:0] histOld;
    logic [WIDTH-1:0] modelDb;
    int               runLen[WIDTH];
    int               vectors = 0;
    int               miscompares = 0;

    button_debouncer #(
        .WIDTH   (WIDTH),
        .CNT_MAX (CNT_MAX)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_in     (btnIn),
        .btn_db     (btnDb),
        .rise_pulse (risePulse),
        .fall_pulse (fallPulse)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        histNew = '0;
        histOld = '0;
        modelDb = '0;
        foreach (runLen[i]) runLen[i] = 0;
    endtask

    // A level is accepted once the input seen two edges ago has disagreed
    // with the current level on CNT_MAX+1 consecutive edges.
    always @(posedge clk or negedge rst_n) begin
        expect_t e;
        e = '0;
        if (!rst_n) begin
            modelOn = 1'b1;
            modelReset();
            expQ.push_back(e);
        end else if (modelOn) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (histOld[i] != modelDb[i]) begin
                    runLen[i]++;
                    if (runLen[i] == CNT_MAX + 1) begin
                        modelDb[i] = histOld[i];
                        runLen[i]  = 0;
                        if (histOld[i]) e.rise[i] = 1'b1;
                        else            e.fall[i] = 1'b1;
                    end
                end else begin
                    runLen[i] = 0;
                end
            end
            histOld = histNew;
            histNew = btnIn;
            e.db    = modelDb;
            expQ.push_back(e);
        end
    end

    task automatic checkOutput(input expect_t e);
        vectors++;
        if ({btnDb, risePulse, fallPulse} !== e) begin
            miscompares++;
            $display("[TB] FAIL outputs at %0t: got db=%b rise=%b fall=%b, expected db=%b rise=%b fall=%b",
                     $time, btnDb, risePulse, fallPulse, e.db, e.rise, e.fall);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            while (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] v, input int cycles);
        btnIn = v;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic pulseReset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] bounce[7];
        bounce = '{3'b011, 3'b011, 3'b001, 3'b011, 3'b011, 3'b011, 3'b001};

        #3;
        pulseReset();
        applyStimulus(3'b000, 20);

        applyStimulus(3'b001, 12);

        foreach (bounce[i]) applyStimulus(bounce[i], 1);
        applyStimulus(3'b001, 10);
        applyStimulus(3'b011, 12);

        applyStimulus(3'b010, 12);

        applyStimulus(3'b000, 12);
        applyStimulus(3'b111, 12);
        applyStimulus(3'b000, 12);

        btnIn = 3'b100;
        repeat (3) @(posedge clk);
        #3;
        pulseReset();
        repeat (12) @(negedge clk);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                #2;
                pulseReset();
            end else if ($urandom_range(0, 3) == 0) begin
                applyStimulus(WIDTH'($urandom_range(0, 7)), $urandom_range(8, 14));
            end else begin
                applyStimulus(WIDTH'($urandom_range(0, 7)), $urandom_range(1, 6));
            end
        end

        repeat (3) @(negedge clk);
        if (vectors < 12) begin
            miscompares++;
            $display("[TB] FAIL vector-count: got %0d, expected at least 12", vectors);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
